herzel_tone_detect: RTL and testbench

- Downstream consumer of the multi-bin Goertzel stage.
- Each time all NF bin powers become valid, it captures them and scans for the strongest bin.
- A bin is accepted when it passes an absolute threshold and a dominance test against the runner-up; the result is debounced over consecutive frames to give a stable tone on/off indication.
- It pulses an acknowledge so the control logic can restart the Goertzel stage for the next frame.

---
 rtl/herzel_tone_detect.sv | 206 ++++++++++++++++++++
 tb/tb_herzel_tone_detect.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/herzel_tone_detect.sv
`default_nettype none
// ============================================================================
// Module   : herzel_tone_detect
// Brief    : Captures a frame of Goertzel bin powers, finds the strongest bin,
//            applies threshold and dominance tests, debounces the result.
// Revision : 1.0 - initial release
// ============================================================================
module herzel_tone_detect #(
  parameter int NF   = 3,
  parameter int DW   = 32,
  parameter int HOLD = 3,
  localparam int IW  = (NF > 1) ? $clog2(NF) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NF-1:0]         res_valid_i,
  input  logic [NF-1:0][DW-1:0] res_data_i,
  input  logic [DW-1:0]         thr_i,
  input  logic [3:0]            ratio_sh_i,
  output logic                  ack_o,
  output logic                  busy_o,
  output logic                  det_o,
  output logic [IW-1:0]         det_idx_o,
  output logic                  tone_on_o,
  output logic [IW-1:0]         tone_idx_o,
  output logic                  tone_start_o,
  output logic                  tone_end_o,
  output logic                  overrun_o,
  output logic [15:0]           frame_cnt_o
);

  // Run counter only needs to reach HOLD (it saturates there).
  localparam int            RW          = $clog2(HOLD + 1);
  localparam logic [IW-1:0] c_last_idx  = IW'(NF - 1);
  localparam logic [RW-1:0] c_hold      = RW'(HOLD);
  localparam logic [RW-1:0] c_run_one   = RW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_DECIDE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_take;
  logic                  w_scan;
  logic                  w_decide;

  logic                  w_all_v;
  logic                  r_all_v_q;
  logic                  w_edge;

  logic [NF-1:0][DW-1:0] r_cap;
  logic [DW-1:0]         r_max;
  logic [DW-1:0]         r_second;
  logic [IW-1:0]         r_max_idx;
  logic [IW-1:0]         r_idx;
  logic [DW-1:0]         w_cur;

  logic [DW+14:0]        w_sh;
  logic                  w_hit;

  logic [RW-1:0]         r_run;
  logic [IW-1:0]         r_last_idx;
  logic [RW-1:0]         w_run_nxt;
  logic [IW-1:0]         w_last_idx_nxt;
  logic                  w_idx_same;
  logic                  w_on_nxt;

  // A new frame is the rising edge of "every bin valid".
  assign w_all_v = &res_valid_i;
  assign w_edge  = w_all_v & ~r_all_v_q;
  assign busy_o  = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and per-state strobes; illegal encodings fall back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_scan      = 1'b0;
    w_decide    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_edge) begin
          w_take      = 1'b1;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        w_scan = 1'b1;
        if (r_idx == c_last_idx) w_state_nxt = S_DECIDE;
      end
      S_DECIDE: begin
        w_decide    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Select the captured bin under scan.
  always_comb begin
    w_cur = '0;
    for (int j = 0; j < NF; j++) begin
      if (r_idx == IW'(j)) w_cur = r_cap[j];
    end
  end

  // Threshold and dominance tests; the shift is widened so it never overflows.
  always_comb begin
    w_sh  = {15'b0, r_second} << ratio_sh_i;
    w_hit = (r_max >= thr_i) && ({15'b0, r_max} >= w_sh);
  end

  // Debounce update: a changed winner restarts the run and always drops an active tone.
  always_comb begin
    w_idx_same     = (r_max_idx == r_last_idx);
    w_run_nxt      = r_run;
    w_last_idx_nxt = r_last_idx;
    if (!w_hit) begin
      w_run_nxt = '0;
    end else if (w_idx_same) begin
      w_run_nxt = (r_run >= c_hold) ? c_hold : r_run + c_run_one;
    end else begin
      w_run_nxt      = c_run_one;
      w_last_idx_nxt = r_max_idx;
    end
    w_on_nxt = (w_run_nxt >= c_hold) && !(w_hit && !w_idx_same && tone_on_o);
  end

  // Frame edge tracking, capture acknowledge and overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_all_v_q <= 1'b0;
      ack_o     <= 1'b0;
      overrun_o <= 1'b0;
      r_cap     <= '0;
    end else begin
      r_all_v_q <= w_all_v;
      ack_o     <= w_take;
      if (w_edge && (r_state != S_IDLE)) overrun_o <= 1'b1;
      if (w_take) r_cap <= res_data_i;
    end
  end

  // Strongest / runner-up scan, one bin per cycle; ties keep the lower index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_max     <= '0;
      r_second  <= '0;
      r_max_idx <= '0;
      r_idx     <= '0;
    end else if (w_take) begin
      r_max     <= '0;
      r_second  <= '0;
      r_max_idx <= '0;
      r_idx     <= '0;
    end else if (w_scan) begin
      if (w_cur > r_max) begin
        r_second  <= r_max;
        r_max     <= w_cur;
        r_max_idx <= r_idx;
      end else if (w_cur > r_second) begin
        r_second <= w_cur;
      end
      r_idx <= r_idx + 1'b1;
    end
  end

  // Decision, frame counter and debounced tone outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      det_o        <= 1'b0;
      det_idx_o    <= '0;
      frame_cnt_o  <= '0;
      r_run        <= '0;
      r_last_idx   <= '0;
      tone_on_o    <= 1'b0;
      tone_idx_o   <= '0;
      tone_start_o <= 1'b0;
      tone_end_o   <= 1'b0;
    end else begin
      tone_start_o <= 1'b0;
      tone_end_o   <= 1'b0;
      if (w_decide) begin
        det_o        <= w_hit;
        det_idx_o    <= r_max_idx;
        frame_cnt_o  <= frame_cnt_o + 16'd1;
        r_run        <= w_run_nxt;
        r_last_idx   <= w_last_idx_nxt;
        tone_on_o    <= w_on_nxt;
        if (w_on_nxt) tone_idx_o <= w_last_idx_nxt;
        tone_start_o <= w_on_nxt & ~tone_on_o;
        tone_end_o   <= ~w_on_nxt & tone_on_o;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_herzel_tone_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_herzel_tone_detect
// Brief    : Self-checking bench for herzel_tone_detect: directed scenarios
//            plus randomized frames against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_herzel_tone_detect;

  localparam int NF   = 3;
  localparam int DW   = 32;
  localparam int HOLD = 3;
  localparam int IW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NF-1:0]         res_valid_i;
  logic [NF-1:0][DW-1:0] res_data_i;
  logic [DW-1:0]         thr_i;
  logic [3:0]            ratio_sh_i;
  logic                  ack_o;
  logic                  busy_o;
  logic                  det_o;
  logic [IW-1:0]         det_idx_o;
  logic                  tone_on_o;
  logic [IW-1:0]         tone_idx_o;
  logic                  tone_start_o;
  logic                  tone_end_o;
  logic                  overrun_o;
  logic [15:0]           frame_cnt_o;

  herzel_tone_detect #(.NF(NF), .DW(DW), .HOLD(HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .res_valid_i  (res_valid_i),
    .res_data_i   (res_data_i),
    .thr_i        (thr_i),
    .ratio_sh_i   (ratio_sh_i),
    .ack_o        (ack_o),
    .busy_o       (busy_o),
    .det_o        (det_o),
    .det_idx_o    (det_idx_o),
    .tone_on_o    (tone_on_o),
    .tone_idx_o   (tone_idx_o),
    .tone_start_o (tone_start_o),
    .tone_end_o   (tone_end_o),
    .overrun_o    (overrun_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ack = 0;
  int n_start = 0;
  int n_end = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit          m_live = 0;
  bit          m_prev = 0;
  bit          m_pending = 0;
  int unsigned t_now = 0;
  int unsigned m_dec_at = 0;
  logic [DW-1:0] m_max, m_second;
  int          m_max_idx = 0;
  int          m_run = 0;
  int          m_last = 0;
  bit          e_ack = 0, e_busy = 0, e_det = 0, e_on = 0, e_start = 0, e_end = 0, e_ovr = 0;
  int          e_det_idx = 0, e_idx = 0;
  logic [15:0] e_cnt = 0;

  always @(posedge clk) begin
    bit all_v, fedge, hit, changed, new_on;
    logic [63:0] lhs, rhs;
    all_v = &res_valid_i;
    fedge = all_v && !m_prev;
    if (rst) begin
      m_live = 1; m_prev = 0; m_pending = 0;
      m_run = 0; m_last = 0;
      e_ack = 0; e_busy = 0; e_det = 0; e_on = 0; e_start = 0; e_end = 0; e_ovr = 0;
      e_det_idx = 0; e_idx = 0; e_cnt = 0;
    end else begin
      m_prev  = all_v;
      e_ack   = 0;
      e_start = 0;
      e_end   = 0;
      if (m_pending) begin
        if (fedge) e_ovr = 1;
        if (t_now == m_dec_at) begin
          lhs = 64'(m_max);
          rhs = 64'(m_second) << ratio_sh_i;
          hit = (m_max >= thr_i) && (lhs >= rhs);
          changed = 0;
          if (hit && m_max_idx == m_last) m_run = (m_run + 1 > HOLD) ? HOLD : m_run + 1;
          else if (hit) begin m_run = 1; m_last = m_max_idx; changed = 1; end
          else m_run = 0;
          new_on  = (m_run >= HOLD) && !(changed && e_on);
          e_start = new_on && !e_on;
          e_end   = !new_on && e_on;
          e_on    = new_on;
          if (new_on) e_idx = m_last;
          e_det     = hit;
          e_det_idx = m_max_idx;
          e_cnt     = e_cnt + 16'd1;
          m_pending = 0;
        end
      end else if (fedge) begin
        // Strongest bin (lowest index on ties) and the largest of the rest.
        m_max_idx = 0;
        for (int j = 1; j < NF; j++) if (res_data_i[j] > res_data_i[m_max_idx]) m_max_idx = j;
        m_max    = res_data_i[m_max_idx];
        m_second = '0;
        for (int j = 0; j < NF; j++) if (j != m_max_idx && res_data_i[j] > m_second) m_second = res_data_i[j];
        m_pending = 1;
        m_dec_at  = t_now + NF + 1;
        e_ack     = 1;
      end
      e_busy = m_pending;
    end
    t_now++;
  end

  // Compare every cycle once the model is anchored by reset.
  always @(negedge clk) begin
    if (m_live) begin
      chk("ack_o", 32'(ack_o), 32'(e_ack));
      chk("busy_o", 32'(busy_o), 32'(e_busy));
      chk("det_o", 32'(det_o), 32'(e_det));
      chk("det_idx_o", 32'(det_idx_o), 32'(e_det_idx));
      chk("tone_on_o", 32'(tone_on_o), 32'(e_on));
      if (e_on) chk("tone_idx_o", 32'(tone_idx_o), 32'(e_idx));
      chk("tone_start_o", 32'(tone_start_o), 32'(e_start));
      chk("tone_end_o", 32'(tone_end_o), 32'(e_end));
      chk("overrun_o", 32'(overrun_o), 32'(e_ovr));
      chk("frame_cnt_o", 32'(frame_cnt_o), 32'(e_cnt));
      if (ack_o === 1'b1) n_ack++;
      if (tone_start_o === 1'b1) n_start++;
      if (tone_end_o === 1'b1) n_end++;
    end
  end

  // One full frame: raise all valids, wait past the decision, drop them.
  task automatic do_frame(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    @(negedge clk);
    res_data_i  = {d2, d1, d0};
    res_valid_i = '1;
    repeat (NF + 4) @(negedge clk);
    res_valid_i = '0;
    @(negedge clk);
  endtask

  initial begin
    int ack_before;
    int win;
    logic [DW-1:0] wv;
    rst         = 1'b1;
    res_valid_i = '0;
    res_data_i  = '0;
    thr_i       = 32'h0001_0000;
    ratio_sh_i  = 4'd2;
    repeat (3) @(negedge clk);
    chk("reset ack", 32'(ack_o), 32'd0);
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset det", 32'(det_o), 32'd0);
    chk("reset tone_on", 32'(tone_on_o), 32'd0);
    chk("reset cnt", 32'(frame_cnt_o), 32'd0);
    rst = 1'b0;

    // Three dominant frames on bin 1 build up a tone.
    repeat (3) do_frame(32'h0000_8000, 32'h0004_0000, 32'h0000_C000);
    chk("t1 det", 32'(det_o), 32'd1);
    chk("t1 det_idx", 32'(det_idx_o), 32'd1);
    chk("t1 tone_on", 32'(tone_on_o), 32'd1);
    chk("t1 tone_idx", 32'(tone_idx_o), 32'd1);
    chk("t1 start count", 32'(n_start), 32'd1);
    chk("t1 cnt", 32'(frame_cnt_o), 32'd3);

    // Tied peaks: lower index wins, dominance fails, tone drops.
    do_frame(32'h0004_0000, 32'h0004_0000, 32'h0000_0000);
    chk("t2 det", 32'(det_o), 32'd0);
    chk("t2 det_idx", 32'(det_idx_o), 32'd0);
    chk("t2 tone_on", 32'(tone_on_o), 32'd0);
    chk("t2 end count", 32'(n_end), 32'd1);

    // Below absolute threshold.
    do_frame(32'h0000_F000, 32'h0000_0000, 32'h0000_0000);
    chk("t3 det", 32'(det_o), 32'd0);
    chk("t3 cnt", 32'(frame_cnt_o), 32'd5);

    // Latency: ack one cycle after the edge, decision NF+2 cycles after.
    @(negedge clk);
    res_data_i  = {32'h0005_0000, 32'h0, 32'h0};
    res_valid_i = '1;
    @(negedge clk);
    chk("lat ack", 32'(ack_o), 32'd1);
    chk("lat busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    chk("lat ack low", 32'(ack_o), 32'd0);
    repeat (2) @(negedge clk);
    chk("lat busy end", 32'(busy_o), 32'd1);
    chk("lat det early", 32'(det_o), 32'd0);
    @(negedge clk);
    chk("lat det", 32'(det_o), 32'd1);
    chk("lat det_idx", 32'(det_idx_o), 32'd2);
    chk("lat busy off", 32'(busy_o), 32'd0);
    res_valid_i = '0;
    @(negedge clk);

    // Overrun: valid re-rises while scanning.
    ack_before = n_ack;
    chk("ovr pre", 32'(overrun_o), 32'd0);
    @(negedge clk);
    res_data_i  = {32'h0, 32'h0, 32'h0004_0000};
    res_valid_i = '1;
    @(negedge clk);
    res_valid_i = '0;
    @(negedge clk);
    res_valid_i = '1;
    repeat (6) @(negedge clk);
    chk("ovr flag", 32'(overrun_o), 32'd1);
    chk("ovr cnt", 32'(frame_cnt_o), 32'd7);
    chk("ovr acks", 32'(n_ack - ack_before), 32'd1);
    res_valid_i = '0;
    @(negedge clk);

    // Reset on the second scan cycle, valid held high.
    res_valid_i = '1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst ovr", 32'(overrun_o), 32'd0);
    chk("rst cnt", 32'(frame_cnt_o), 32'd0);
    chk("rst det", 32'(det_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst ack", 32'(ack_o), 32'd1);
    repeat (5) @(negedge clk);
    chk("post-rst cnt", 32'(frame_cnt_o), 32'd1);
    res_valid_i = '0;
    @(negedge clk);

    // Randomized frames, including short frames (overruns) and sporadic resets.
    win = 0;
    for (int f = 0; f < 300; f++) begin
      @(negedge clk);
      rst = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 3) == 0) win = $urandom_range(0, NF - 1);
        wv = DW'($urandom_range(32'h0000_4000, 32'h000F_0000));
        for (int j = 0; j < NF; j++) res_data_i[j] = DW'($urandom_range(0, 32'h0000_FFFF));
        res_data_i[win] = wv;
        if ($urandom_range(0, 7) == 0) res_data_i[(win + 1) % NF] = wv;
        ratio_sh_i = 4'($urandom_range(0, 3));
      end
      res_valid_i = '1;
      repeat ($urandom_range(1, 8)) begin
        @(negedge clk);
        rst = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 7) == 0) thr_i = DW'($urandom_range(32'h0000_8000, 32'h0002_0000));
      end
      res_valid_i = NF'($urandom_range(0, (1 << NF) - 2));
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        rst = 1'b0;
      end
    end
    rst = 1'b0;
    res_valid_i = '0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
